// File: rtl/lbist_controller.sv
// Logic BIST controller. It generates LFSR scan patterns, sequences the shift and
// capture cycles, compacts scan-out data into a MISR and compares the result with a golden signature.
module lbist_controller #(
    parameter int                    NUM_CHAINS       = 8,
    parameter int                    CHAIN_LEN        = 16,
    parameter int                    NUM_PATTERNS     = 1024,
    parameter int                    LFSR_WIDTH       = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED        = 32'hACE1_0001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY        = 32'h8020_0003,
    parameter int                    MISR_WIDTH       = 32,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY        = 32'h8020_0003,
    parameter logic [MISR_WIDTH-1:0] GOLDEN_SIGNATURE = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  normal_test_i,
    output logic [NUM_CHAINS-1:0] scan_in_o,
    input  logic [NUM_CHAINS-1:0] scan_out_i,
    output logic                  scan_en_o,
    output logic                  busy_o,
    output logic                  test_over_o,
    output logic                  go_nogo_o,
    output logic [MISR_WIDTH-1:0] signature_o
);

    localparam int PW = $clog2(NUM_PATTERNS + 1);
    localparam int SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS);
    localparam logic [SW-1:0] SH_LAST  = SW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_step;
    logic [MISR_WIDTH-1:0]   misr_q, misr_d, misr_step;
    logic [PW-1:0]           pat_q, pat_d;
    logic [SW-1:0]           sh_q, sh_d;
    logic                    pass_q, pass_d;
    logic                    prev_q;
    logic                    start;

    assign start       = normal_test_i & ~prev_q & test_mode_i;
    assign signature_o = misr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            pat_q   <= '0;
            sh_q    <= '0;
            pass_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            pass_q  <= pass_d;
            prev_q  <= normal_test_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        misr_d      = misr_q;
        pat_d       = pat_q;
        sh_d        = sh_q;
        pass_d      = pass_q;
        scan_en_o   = 1'b0;
        scan_in_o   = '0;
        busy_o      = 1'b0;
        test_over_o = 1'b0;
        go_nogo_o   = 1'b0;

        lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
        misr_step = (misr_q[0] ? ((misr_q >> 1) ^ MISR_POLY) : (misr_q >> 1))
                    ^ MISR_WIDTH'(scan_out_i);

        case (state_q)
            IDLE: ;
            SHIFT: begin
                scan_en_o = 1'b1;
                scan_in_o = lfsr_q[NUM_CHAINS-1:0];
                busy_o    = 1'b1;
                lfsr_d    = lfsr_step;
                misr_d    = misr_step;
                sh_d      = sh_q + SW'(1);
                if (sh_q == SH_LAST) begin
                    sh_d    = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                busy_o  = 1'b1;
                pat_d   = pat_q + PW'(1);
                state_d = (pat_d == PAT_LAST) ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                scan_en_o = 1'b1;
                busy_o    = 1'b1;
                misr_d    = misr_step;
                sh_d      = sh_q + SW'(1);
                if (sh_q == SH_LAST) begin
                    sh_d    = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                busy_o  = 1'b1;
                pass_d  = (misr_q == GOLDEN_SIGNATURE);
                state_d = DONE;
            end
            DONE: begin
                test_over_o = 1'b1;
                go_nogo_o   = pass_q;
            end
            default: state_d = IDLE;
        endcase

        // Leaving test mode mid-run wipes everything so the next run starts clean.
        if (busy_o && !test_mode_i) begin
            state_d = IDLE;
            lfsr_d  = '0;
            misr_d  = '0;
            pat_d   = '0;
            sh_d    = '0;
            pass_d  = 1'b0;
        end

        if (start && (state_q == IDLE || state_q == DONE)) begin
            state_d = SHIFT;
            lfsr_d  = LFSR_SEED;
            misr_d  = '0;
            pat_d   = '0;
            sh_d    = '0;
            pass_d  = 1'b0;
        end
    end

endmodule

// File: doc/lbist_controller.md
Name: lbist_controller

Overview:
- Core-side responder to the LBIST test-control interface. The testbench drives a `normal_test_i` start pulse; this block answers with `test_over_o` and `go_nogo_o`.
- On start it runs a self-test:
  - generates pseudo-random scan patterns with an LFSR;
  - sequences shift and capture cycles on the core's scan chains;
  - compacts the scan-out data in a MISR;
  - compares the final signature against a golden value.
- Sits inside the riscv wrapper, between the top-level test pins and the core's scan-compression chains.

Parameters:
- NUM_CHAINS, 8, number of scan chains driven and observed in parallel.
- CHAIN_LEN, 16, shift cycles per pattern (length of the longest chain).
- NUM_PATTERNS, 1024, patterns applied per run.
- LFSR_WIDTH, 32, pattern-generator width; must be >= NUM_CHAINS.
- LFSR_SEED, 32'hACE1_0001, LFSR value loaded at start; must be nonzero.
- LFSR_POLY, 32'h8020_0003, Galois feedback mask for the LFSR.
- MISR_WIDTH, 32, signature register width; must be >= NUM_CHAINS.
- MISR_POLY, 32'h8020_0003, Galois feedback mask for the MISR.
- GOLDEN_SIGNATURE, 32'h0000_0000, expected final MISR value.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: synchronous, active-low.
- test_mode_i  in  1  scan-compression test mode enable; a run proceeds only while this is 1.
- normal_test_i  in  1  start request; a rising edge starts a run.
- scan_in_o  out  NUM_CHAINS  scan-chain inputs.
- scan_out_i  in  NUM_CHAINS  scan-chain outputs.
- scan_en_o  out  1  1 = shift, 0 = functional capture.
- busy_o  out  1  a run is in progress.
- test_over_o  out  1  run complete; result valid.
- go_nogo_o  out  1  1 = signature matched; valid while test_over_o = 1.
- signature_o  out  MISR_WIDTH  current MISR contents.

Behaviour:
- Reset (rst_ni = 0 at a clk_i edge):
  - FSM goes to IDLE; LFSR, MISR and all counters are cleared.
  - Outputs become 0: scan_en_o, scan_in_o, busy_o, test_over_o, go_nogo_o, signature_o.
  - Reset mid-run aborts the run with no residue.
- Start detection:
  - A registered copy of normal_test_i is kept.
  - start = normal_test_i & ~prev & test_mode_i.
  - start is honoured only in IDLE or DONE.
- Actions on start:
  - LFSR <= LFSR_SEED; MISR <= 0; pattern counter <= 0; shift counter <= 0.
  - Next state is SHIFT.
  - test_over_o and go_nogo_o drop in the same edge.
- FSM states:
  - IDLE: busy_o = 0.
  - SHIFT: CHAIN_LEN cycles.
    - scan_en_o = 1; scan_in_o = LFSR[NUM_CHAINS-1:0].
    - LFSR advances every cycle.
    - MISR compacts scan_out_i every cycle.
    - After the last shift cycle -> CAPTURE.
  - CAPTURE: 1 cycle.
    - scan_en_o = 0; LFSR and MISR hold; pattern counter increments.
    - If the counter reaches NUM_PATTERNS -> UNLOAD, else -> SHIFT.
  - UNLOAD: CHAIN_LEN cycles.
    - scan_en_o = 1; scan_in_o = 0; MISR compacts.
    - Then -> COMPARE.
  - COMPARE: 1 cycle.
    - go_nogo result is registered as (MISR == GOLDEN_SIGNATURE).
    - Then -> DONE.
  - DONE: test_over_o = 1; go_nogo_o holds the result; busy_o = 0.
    - Stays in DONE until reset or a new start.
- busy_o = 1 in SHIFT, CAPTURE, UNLOAD and COMPARE.
- LFSR step: next = lsb ? (lfsr >> 1) ^ LFSR_POLY : lfsr >> 1.
- MISR step: next = galois(misr, MISR_POLY) ^ zero-extended scan_out_i.
- Latency: test_over_o rises exactly NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles after the edge that sampled start.
- normal_test_i held high: produces only one run. Edges arriving during a run are ignored.
- test_mode_i = 0 while busy: abort.
  - Next edge goes to IDLE with all outputs 0.
  - test_over_o is never asserted for that run.
- test_mode_i = 0 in DONE: results hold.
- Counter widths: $clog2 of NUM_PATTERNS+1 and of CHAIN_LEN. No wrap-around is permitted before the terminal count.

Test Plan:
Directed runs use NUM_CHAINS = 2, CHAIN_LEN = 3, NUM_PATTERNS = 4.
- Reset check: hold rst_ni = 0 for 4 cycles with normal_test_i toggling -> all outputs 0 and busy_o = 0 throughout.
- Zero-input pass: scan_out_i = 0, GOLDEN = 0, one-cycle start pulse ->
  - scan_in_o = 2'b01 (seed[1:0]) in the first SHIFT cycle;
  - test_over_o rises 4*4+3+1 = 20 cycles after start;
  - signature_o = 0 and go_nogo_o = 1.
- Zero-input fail: same stimulus with GOLDEN = 32'h1 -> test_over_o at cycle 20 with go_nogo_o = 0.
- Loopback: scan_out_i = scan_in_o delayed 3 cycles (chain model) ->
  - signature_o equals the bench reference model and go_nogo_o = 1 with GOLDEN set to the model value;
  - inverting scan_out_i[0] for one cycle -> go_nogo_o = 0.
- Abort: drop test_mode_i at cycle 7 of a run ->
  - IDLE on the next edge with busy_o = 0 and test_over_o = 0;
  - a restart yields the same signature as an uninterrupted run.
- Start filtering: hold normal_test_i high for 40 cycles, plus a pulse at cycle 10 of a second run -> exactly one completion per rising edge; the mid-run pulse is ignored.
